// File: rtl/detect_count_display_if.sv
// Signal bundle for detect_count_display: control inputs plus display/count outputs.
interface detect_count_display_if;
   logic       ena;
   logic       det;
   logic       clr;
   logic       digit_sel;
   logic [7:0] seg;
   logic [7:0] count;
   logic       ovf;

   modport master (output ena, det, clr, digit_sel, input seg, count, ovf);
   modport slave  (input ena, det, clr, digit_sel, output seg, count, ovf);
endinterface

// File: rtl/detect_count_display.sv
// Two-digit BCD detection counter with sticky overflow, 7-segment decode and dp hold timer.
// Define DET_EDGE_EN to count rising edges of det instead of every high cycle.
module detect_count_display #(
   parameter int unsigned HOLD_CYCLES = 4
) (
   input logic clk,
   input logic rst_n,
   detect_count_display_if.slave bus
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t     state;
   logic [7:0] hold_cnt;
   logic [3:0] tens;
   logic [3:0] units;
   logic       ovf_r;
   logic       det_evt;
   logic [3:0] nib;
   logic [6:0] dec;

`ifdef DET_EDGE_EN
   logic det_q;

   // Edge register keeps sampling during clr so a held det is not recounted afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         det_q <= 1'b0;
      else if (bus.ena)
         det_q <= bus.det;
   end

   assign det_evt = bus.det & ~det_q;
`else
   assign det_evt = bus.det;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         hold_cnt <= '0;
         tens     <= '0;
         units    <= '0;
         ovf_r    <= 1'b0;
      end else if (bus.ena) begin
         if (bus.clr) begin
            state    <= IDLE;
            hold_cnt <= '0;
            tens     <= '0;
            units    <= '0;
            ovf_r    <= 1'b0;
         end else if (det_evt) begin
            state    <= HOLD;
            hold_cnt <= 8'(HOLD_CYCLES);
            if (units == 4'd9) begin
               units <= '0;
               if (tens == 4'd9) begin
                  tens  <= '0;
                  ovf_r <= 1'b1;
               end else begin
                  tens <= tens + 4'd1;
               end
            end else begin
               units <= units + 4'd1;
            end
         end else if (state == HOLD) begin
            hold_cnt <= hold_cnt - 8'd1;
            if (hold_cnt == 8'd1)
               state <= IDLE;
         end
      end
   end

   always_comb begin
      nib = bus.digit_sel ? tens : units;
      case (nib)
         4'd0:    dec = 7'h3F;
         4'd1:    dec = 7'h06;
         4'd2:    dec = 7'h5B;
         4'd3:    dec = 7'h4F;
         4'd4:    dec = 7'h66;
         4'd5:    dec = 7'h6D;
         4'd6:    dec = 7'h7D;
         4'd7:    dec = 7'h07;
         4'd8:    dec = 7'h7F;
         4'd9:    dec = 7'h6F;
         default: dec = 7'h00;
      endcase
   end

   assign bus.seg   = {state == HOLD, dec};
   assign bus.count = {tens, units};
   assign bus.ovf   = ovf_r;

endmodule

// File: tb/tb_detect_count_display.sv
// Self-checking bench for detect_count_display: directed scenarios plus random traffic vs an integer model.
module tb_detect_count_display;

   localparam int unsigned HOLD = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   // Reference state: decimal count, sticky overflow, remaining dp cycles, last sampled det.
   int   m_cnt = 0;
   int   m_ovf = 0;
   int   m_rem = 0;
   int   m_prev = 0;
   logic [7:0] segtab [10];

   detect_count_display_if bus ();

   detect_count_display #(.HOLD_CYCLES(HOLD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] exp_count();
      return 8'(((m_cnt / 10) << 4) | (m_cnt % 10));
   endfunction

   function automatic logic [7:0] exp_seg();
      int d;
      d = bus.digit_sel ? m_cnt / 10 : m_cnt % 10;
      return segtab[d] | ((m_rem > 0) ? 8'h80 : 8'h00);
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_ovf = 0; m_rem = 0; m_prev = 0;
   endtask

   task automatic check_all(input string tag);
      check({tag, "_cnt"}, 32'(bus.count), 32'(exp_count()));
      check({tag, "_ovf"}, 32'(bus.ovf), 32'(m_ovf));
      check({tag, "_seg"}, 32'(bus.seg), 32'(exp_seg()));
   endtask

   // Drive one cycle of inputs, verify seg follows digit_sel at once, then clock and verify.
   task automatic step(input logic e, input logic d, input logic c, input logic s);
      bit evt;
      bus.ena = e; bus.det = d; bus.clr = c; bus.digit_sel = s;
      #1;
      check("comb_seg", 32'(bus.seg), 32'(exp_seg()));
      @(posedge clk);
`ifdef DET_EDGE_EN
      evt = e && !c && d && (m_prev == 0);
`else
      evt = e && !c && d;
`endif
      if (e) begin
         if (c) begin
            m_cnt = 0; m_ovf = 0; m_rem = 0;
         end else if (evt) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == 100) begin
               m_cnt = 0; m_ovf = 1;
            end
            m_rem = HOLD;
         end else if (m_rem > 0) begin
            m_rem = m_rem - 1;
         end
         m_prev = d;
      end
      #1;
      check_all("step");
   endtask

   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1 model_reset();
      check("arst_seg", 32'(bus.seg), 32'(exp_seg()));
      check("arst_cnt", 32'(bus.count), 32'h00);
      check("arst_ovf", 32'(bus.ovf), 32'h0);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      int dp_run;
      logic [7:0] held;
      segtab = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
      bus.ena = 1'b0; bus.det = 1'b0; bus.clr = 1'b0; bus.digit_sel = 1'b0;

      // Reset state
      #12;
      check("rst_seg", 32'(bus.seg), 32'h3F);
      check("rst_cnt", 32'(bus.count), 32'h00);
      check("rst_ovf", 32'(bus.ovf), 32'h0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Three isolated pulses, dp trailing for HOLD cycles
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 0, 0);
         if (i < 2) step(1, 0, 0, 0);
      end
      check("p3_cnt", 32'(bus.count), 32'h03);
      check("p3_seg_dp", 32'(bus.seg), 32'hCF);
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
      check("p3_seg_nodp", 32'(bus.seg), 32'h4F);

      // Wrap through 99 and sticky overflow, then clear
      step(1, 0, 1, 0);
      for (int i = 0; i < 99; i++) begin
         step(1, 1, 0, 1);
         step(1, 0, 0, 1);
      end
      check("w99_cnt", 32'(bus.count), 32'h99);
      check("w99_seg", 32'(bus.seg & 8'h7F), 32'h6F);
      step(1, 1, 0, 1);
      check("w100_cnt", 32'(bus.count), 32'h00);
      check("w100_ovf", 32'(bus.ovf), 32'h1);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
      check("ovf_sticky", 32'(bus.ovf), 32'h1);
      step(1, 0, 1, 0);
      check("clr_cnt", 32'(bus.count), 32'h00);
      check("clr_ovf", 32'(bus.ovf), 32'h0);
      check("clr_seg", 32'(bus.seg), 32'h3F);

      // det held high for five cycles
      for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
      step(1, 0, 0, 0);
`ifdef DET_EDGE_EN
      check("held_cnt", 32'(bus.count), 32'h01);
`else
      check("held_cnt", 32'(bus.count), 32'h05);
`endif

      // Retrigger: dp stays lit 2+HOLD cycles in a row
      step(1, 0, 1, 0);
      step(1, 1, 0, 0);
      dp_run = bus.seg[7] ? 1 : 0;
      step(1, 0, 0, 0);
      if (bus.seg[7]) dp_run++;
      step(1, 1, 0, 0);
      if (bus.seg[7]) dp_run++;
      for (int i = 0; i < 20 && bus.seg[7]; i++) begin
         step(1, 0, 0, 0);
         if (bus.seg[7]) dp_run++;
      end
      check("retrig_dp_len", 32'(dp_run), 32'(2 + HOLD));

      // Disabled cycles freeze count and dp timer
      step(1, 0, 0, 0);
      step(1, 1, 0, 0);
      held = bus.count;
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
      check("ena0_cnt", 32'(bus.count), 32'(held));
      check("ena0_dp", 32'(bus.seg[7]), 32'h1);
      step(1, 0, 0, 0);

      // clr beats det at 07, then async reset mid-HOLD
      step(1, 0, 1, 0);
      for (int i = 0; i < 7; i++) begin
         step(1, 1, 0, 0);
         step(1, 0, 0, 0);
      end
      check("c7_cnt", 32'(bus.count), 32'h07);
      step(1, 1, 1, 0);
      check("clrdet_cnt", 32'(bus.count), 32'h00);
      check("clrdet_dp", 32'(bus.seg[7]), 32'h0);
      step(1, 0, 0, 0);
      step(1, 1, 0, 0);
      check("prearst_dp", 32'(bus.seg[7]), 32'h1);
      async_reset();
      check("arst_seg3f", 32'(bus.seg), 32'h3F);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 7) != 0), 1'($urandom), ($urandom_range(0, 40) == 0), 1'($urandom));
         if ($urandom_range(0, 250) == 0) async_reset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
